// File: rtl/count_dir_pkg.sv
// Shared types for the count direction decoder: FSM states and per-step classes.
package count_dir_pkg;

  typedef enum logic [1:0] {
    S_INIT = 2'd0,
    S_ACQ  = 2'd1,
    S_UP   = 2'd2,
    S_DOWN = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    STEP_UP = 2'd0,
    STEP_DN = 2'd1,
    HOLD    = 2'd2,
    ILLEGAL = 2'd3
  } step_t;

endpackage

// File: rtl/count_step_classifier.sv
// Combinational: classifies the modular step prev -> count and flags wrap-around.
module count_step_classifier
  import count_dir_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] prev_i,
  input  logic [WIDTH-1:0] count_i,
  output step_t            step_o,
  output logic             wrap_o
);

  logic [WIDTH-1:0] delta;

  assign delta = count_i - prev_i;

  always_comb begin
    step_o = ILLEGAL;
    if (delta == WIDTH'(1))       step_o = STEP_UP;
    else if (delta == '1)         step_o = STEP_DN;
    else if (delta == '0)         step_o = HOLD;
  end

  // Up out of the max code or down out of zero crosses the modulus boundary.
  assign wrap_o = ((step_o == STEP_UP) && (prev_i == '1)) ||
                  ((step_o == STEP_DN) && (prev_i == '0));

endmodule

// File: rtl/count_dir_decoder.sv
// Monitors an up/down counter bus, recovers its direction, lock status, wrap and
// reversal pulses and a saturating run length. All outputs registered, one edge late.
module count_dir_decoder
  import count_dir_pkg::*;
#(
  parameter int WIDTH    = 3,
  parameter int LOCK_CNT = 2,
  parameter int RUN_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] count_in,
  output logic             dir_out,
  output logic             locked,
  output logic             step_err,
  output logic             wrap_pulse,
  output logic             dir_change,
  output logic [RUN_W-1:0] run_len
);

  localparam logic [RUN_W-1:0] RUN_MAX  = '1;
  localparam logic [RUN_W-1:0] LOCK_TGT = RUN_W'(LOCK_CNT);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] prev_q;
  logic [RUN_W-1:0] lock_cnt_q, lock_cnt_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic             dir_q, dir_d;
  logic             locked_q, locked_d;
  logic             err_q, err_d;
  logic             wrap_q, wrap_d;
  logic             chg_q, chg_d;

  step_t            step;
  logic             wrap;
  logic             going_up;
  logic             same_dir;

  count_step_classifier #(
    .WIDTH (WIDTH)
  ) u_classifier (
    .prev_i  (prev_q),
    .count_i (count_in),
    .step_o  (step),
    .wrap_o  (wrap)
  );

  assign going_up = (step == STEP_UP);
  assign same_dir = ((state_q == S_UP) && going_up) ||
                    ((state_q == S_DOWN) && !going_up);

  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    run_d      = run_q;
    dir_d      = dir_q;
    err_d      = 1'b0;
    wrap_d     = 1'b0;
    chg_d      = 1'b0;

    if (state_q == S_INIT) begin
      state_d = S_ACQ;
    end else begin
      unique case (step)
        STEP_UP, STEP_DN: begin
          wrap_d  = wrap;
          dir_d   = going_up;
          state_d = going_up ? S_UP : S_DOWN;
          if (state_q == S_ACQ) begin
            run_d      = RUN_W'(1);
            lock_cnt_d = RUN_W'(1);
          end else if (same_dir) begin
            run_d      = (run_q == RUN_MAX) ? run_q : run_q + RUN_W'(1);
            lock_cnt_d = (lock_cnt_q >= LOCK_TGT) ? lock_cnt_q : lock_cnt_q + RUN_W'(1);
          end else begin
            chg_d      = 1'b1;
            run_d      = RUN_W'(1);
            lock_cnt_d = RUN_W'(1);
          end
        end
        ILLEGAL: begin
          err_d      = 1'b1;
          state_d    = S_ACQ;
          run_d      = '0;
          lock_cnt_d = '0;
        end
        default: begin
          // Stalls leave direction, run and lock untouched.
        end
      endcase
    end

    locked_d = ((state_d == S_UP) || (state_d == S_DOWN)) && (lock_cnt_d >= LOCK_TGT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_INIT;
      prev_q     <= '0;
      lock_cnt_q <= '0;
      run_q      <= '0;
      dir_q      <= 1'b0;
      locked_q   <= 1'b0;
      err_q      <= 1'b0;
      wrap_q     <= 1'b0;
      chg_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      prev_q     <= count_in;
      lock_cnt_q <= lock_cnt_d;
      run_q      <= run_d;
      dir_q      <= dir_d;
      locked_q   <= locked_d;
      err_q      <= err_d;
      wrap_q     <= wrap_d;
      chg_q      <= chg_d;
    end
  end

  assign dir_out    = dir_q;
  assign locked     = locked_q;
  assign step_err   = err_q;
  assign wrap_pulse = wrap_q;
  assign dir_change = chg_q;
  assign run_len    = run_q;

endmodule

// File: tb/tb_count_dir_decoder.sv
// Directed and random stimulus for count_dir_decoder, checked against a step-history model.
module tb_count_dir_decoder;

  localparam int WIDTH    = 3;
  localparam int LOCK_CNT = 2;
  localparam int MASK     = (1 << WIDTH) - 1;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] count_in;

  logic       dir_out, locked, step_err, wrap_pulse, dir_change;
  logic [7:0] run_len;
  logic       dir_out2, locked2, step_err2, wrap_pulse2, dir_change2;
  logic [1:0] run_len2;

  count_dir_decoder #(.WIDTH(WIDTH), .LOCK_CNT(LOCK_CNT), .RUN_W(8)) dut (
    .clk(clk), .rst(rst), .count_in(count_in),
    .dir_out(dir_out), .locked(locked), .step_err(step_err),
    .wrap_pulse(wrap_pulse), .dir_change(dir_change), .run_len(run_len)
  );

  count_dir_decoder #(.WIDTH(WIDTH), .LOCK_CNT(LOCK_CNT), .RUN_W(2)) dut_w2 (
    .clk(clk), .rst(rst), .count_in(count_in),
    .dir_out(dir_out2), .locked(locked2), .step_err(step_err2),
    .wrap_pulse(wrap_pulse2), .dir_change(dir_change2), .run_len(run_len2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Model: remembers the last sample and the current run of same-direction steps.
  bit m_started, m_resolved, m_dir;
  int m_prev, m_run, m_streak;
  bit e_err, e_wrap, e_chg;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_started = 0; m_resolved = 0; m_dir = 0;
    m_prev = 0; m_run = 0; m_streak = 0;
    e_err = 0; e_wrap = 0; e_chg = 0;
  endtask

  task automatic model_step(input int v);
    int  d;
    bit  up;
    e_err = 0; e_wrap = 0; e_chg = 0;
    if (!m_started) begin
      m_started = 1;
      m_prev = v;
      return;
    end
    d = (v - m_prev) & MASK;
    if (d == 1 || d == MASK) begin
      up = (d == 1);
      e_wrap = up ? (m_prev == MASK) : (m_prev == 0);
      if (m_resolved && m_dir != up) begin
        e_chg = 1; m_run = 1; m_streak = 1;
      end else if (m_resolved) begin
        m_run++; m_streak++;
      end else begin
        m_run = 1; m_streak = 1;
      end
      m_resolved = 1;
      m_dir = up;
    end else if (d != 0) begin
      e_err = 1; m_resolved = 0; m_run = 0; m_streak = 0;
    end
    m_prev = v;
  endtask

  task automatic check_all(input string tag);
    int lk;
    lk = (m_resolved && m_streak >= LOCK_CNT) ? 1 : 0;
    check({tag, ".dir"},     dir_out,    m_dir);
    check({tag, ".locked"},  locked,     lk);
    check({tag, ".err"},     step_err,   e_err);
    check({tag, ".wrap"},    wrap_pulse, e_wrap);
    check({tag, ".chg"},     dir_change, e_chg);
    check({tag, ".run"},     run_len,    (m_run > 255) ? 255 : m_run);
    check({tag, ".run_w2"},  run_len2,   (m_run > 3) ? 3 : m_run);
  endtask

  task automatic tick(input int v, input string tag);
    count_in = WIDTH'(v);
    @(posedge clk);
    #1;
    model_step(v);
    check_all(tag);
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".dir"},    dir_out,    0);
    check({tag, ".locked"}, locked,     0);
    check({tag, ".err"},    step_err,   0);
    check({tag, ".wrap"},   wrap_pulse, 0);
    check({tag, ".chg"},    dir_change, 0);
    check({tag, ".run"},    run_len,    0);
    check({tag, ".run_w2"}, run_len2,   0);
  endtask

  initial begin
    int cur;
    int dir;
    int r;
    rst = 1'b1;
    count_in = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;

    // Up through the wrap: 0..7,0,1
    for (int i = 0; i < 10; i++) tick(i & MASK, "t1_up");
    check("t1_run9", run_len, 9);

    // Up to 4 then down through 0 -> 7
    tick(2, "t2_up"); tick(3, "t2_up"); tick(4, "t2_up");
    tick(3, "t2_rev"); tick(2, "t2_dn"); tick(1, "t2_dn");
    tick(0, "t2_dn"); tick(7, "t2_wrap");

    // Holds do not break lock
    tick(2, "t4_jump"); tick(3, "t4_acq"); tick(3, "t4_hold");
    tick(3, "t4_hold"); tick(4, "t4_up"); tick(5, "t4_up");
    tick(5, "t4_hold");

    // Illegal jump then reacquisition
    tick(2, "t5_a"); tick(3, "t5_b"); tick(6, "t5_ill"); tick(7, "t5_reacq");
    check("t5_run1", run_len, 1);

    // up_down_counter style: reverse every 7 cycles for 50 cycles
    cur = 7; dir = 1;
    for (int i = 0; i < 50; i++) begin
      if (i % 7 == 0 && i != 0) dir = -dir;
      cur = (cur + dir) & MASK;
      tick(cur, "t3_osc");
    end

    // Async reset between edges, synchronous release
    count_in = WIDTH'((cur + dir) & MASK);
    #3 rst = 1'b1;
    #1;
    check_zero("t6_async");
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    tick(5, "t6_init");
    for (int i = 6; i < 12; i++) tick(i & MASK, "t6_sat");

    // Random walk: steps, reversals, holds and occasional jumps
    cur = 0; dir = 1;
    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 19));
      if (r < 11)      cur = (cur + dir) & MASK;
      else if (r < 14) begin dir = -dir; cur = (cur + dir) & MASK; end
      else if (r < 18) cur = cur;
      else             cur = int'($urandom_range(0, MASK));
      tick(cur, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
